acc_accumulate_ctrl: RTL and testbench
======================================

// Module: acc_accumulate_ctrl
// PURPOSE
//  Read-modify-write front end for the accumulator memory. Takes partial sums streamed out of the systolic array
//  (valid/ready, one word per beat) and adds each one into the accumulator word at its address, or overwrites that word.
//  Sits directly upstream of the accumulator memory, which has a combinational read (OUTPUT_REG=0) and writes on negedge.
//  Shares the memory read port with the downstream readout engine, and signals done when a tile set is fully written.
// PARAMETERS
//  PSUM_WIDTH  32  width of incoming signed partial sum
//  ACC_WIDTH   32  accumulator word width; equals the memory DATA_WIDTH; must be >= PSUM_WIDTH
//  ADDR_WIDTH  12  accumulator address width
//  SATURATE    0   0: two's-complement wrap; 1: clamp to signed ACC_WIDTH min/max
//  CNT_WIDTH   16  width of beat_count
// PORTS
//  clk             in   1           clock
//  reset           in   1           asynchronous, active-low reset
//  in_valid        in   1           partial-sum beat valid
//  in_ready        out  1           beat accepted when in_valid & in_ready
//  in_addr         in   ADDR_WIDTH  target accumulator address
//  in_data         in   PSUM_WIDTH  signed partial sum
//  in_first        in   1           1: overwrite (word = psum); 0: accumulate (word += psum)
//  in_last         in   1           final beat of the tile set
//  ext_rd_req      in   1           readout engine requests the memory read port
//  ext_rd_addr     in   ADDR_WIDTH  readout address
//  mem_read_req    out  1           to memory read_req
//  mem_read_addr   out  ADDR_WIDTH  to memory read_addr
//  mem_read_data   in   ACC_WIDTH   from memory read_data (combinational)
//  mem_write_req   out  1           to memory write_req
//  mem_write_addr  out  ADDR_WIDTH  to memory write_addr
//  mem_write_data  out  ACC_WIDTH   to memory write_data
//  busy            out  1           state != IDLE
//  done            out  1           1-cycle pulse after the in_last write is issued
//  beat_count      out  CNT_WIDTH   beats accepted since the last IDLE->ACCUM transition
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0 (in_ready=0 while in reset), state=IDLE, S1 invalid, beat_count=0.
//    Any beat in flight is dropped. Memory contents are cleared separately by the top level.
//  in_ready = reset & ~ext_rd_req & (state != DRAIN). ext_rd_req always wins the read port:
//    mem_read_addr = ext_rd_req ? ext_rd_addr : in_addr; mem_read_req = ext_rd_req | (in_valid & in_ready).
//  Pipeline, 2 stages:
//    S0 (accept cycle): operand = fwd ? s1_data : mem_read_data, where fwd = s1_valid & (s1_addr == in_addr).
//    Forwarding is mandatory: the memory write happens on negedge, so without it a back-to-back same-address read is stale.
//    S1 register (posedge): s1_valid <= accepted; s1_addr <= in_addr; s1_data <= in_first ? sx(in_data) : op(operand, sx(in_data)).
//    Writes: mem_write_req = s1_valid; mem_write_addr = s1_addr; mem_write_data = s1_data.
//  Latency: a beat accepted in cycle N is written in cycle N+1. Throughput is 1 beat/cycle, including repeated same-address beats.
//  Arithmetic: sx = sign-extend to ACC_WIDTH. op is a wrapping add when SATURATE=0.
//    With SATURATE=1, op clamps on signed overflow: pos+pos->0x7FF..F, neg+neg->0x800..0.
//  FSM:
//    IDLE -accepted beat-> ACCUM; beat_count restarts at 1 on this transition.
//    ACCUM/IDLE -accepted beat with in_last-> DRAIN.
//    DRAIN -> IDLE on the next cycle (the S1 write completes); done=1 in that DRAIN cycle.
//    A single beat with in_last set in IDLE goes directly IDLE->DRAIN.
//  beat_count increments on each accepted beat and saturates at all-ones.
//  Readout coherence: ext reads are coherent only while busy=0. A read issued while busy may return pre-write data.
//  in_valid while in_ready=0: the beat is held upstream; payload must stay stable until accepted.
// STRUCTURE
//  Shared package acc_pkg holds: the state enum (IDLE/ACCUM/DRAIN), the ACC_MAX/ACC_MIN constants, and the sat_add function.
//  One sub-module, acc_add_sat: combinational sign-extend plus wrap/saturating add, parameterised by SATURATE.
//  FSM, forwarding mux and S1 register live in the top module.
// TESTING
//  T1: mem[5]=10. Beat addr=5, data=3, first=0, last=1. -> write 13 to addr 5 one cycle later; done pulses next cycle; busy falls.
//  T2: four back-to-back beats to addr 7, data 1,2,3,4, first=1 on the first beat.
//      -> writes 1,3,6,10 on consecutive cycles (forwarding exercised); beat_count=4.
//  T3: ext_rd_req held 3 cycles mid-stream. -> in_ready=0 for exactly those cycles; mem_read_addr=ext_rd_addr; no beat lost or duplicated.
//  T4: SATURATE=1, mem[0]=0x7FFFFFF0, data=0x20. -> write 0x7FFFFFFF.
//      SATURATE=0 with the same stimulus -> write 0x80000010.
//  T5: PSUM_WIDTH=16, data=0xFFFF, mem=5. -> write 4 (sign-extension check).
//  T6: reset asserted while in ACCUM with S1 valid. -> mem_write_req drops immediately; state=IDLE, done=0, beat_count=0.
//      After release, the next beat starts from IDLE.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types, constants and arithmetic for the accumulator read-modify-write front end.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Arithmetic is done at this fixed width; narrower accumulators sign-extend into it.
    localparam int ACC_WMAX = 64;
    localparam logic signed [ACC_WMAX-1:0] ACC_MAX = {1'b0, {(ACC_WMAX-1){1'b1}}};
    localparam logic signed [ACC_WMAX-1:0] ACC_MIN = {1'b1, {(ACC_WMAX-1){1'b0}}};

    // Adds two sign-extended operands; with saturate set, clamps to the signed range of 'width' bits.
    function automatic logic [ACC_WMAX-1:0] sat_add(input logic [ACC_WMAX-1:0] a,
                                                    input logic [ACC_WMAX-1:0] b,
                                                    input int                  width,
                                                    input bit                  saturate);
        logic signed [ACC_WMAX:0] sum;
        logic signed [ACC_WMAX:0] hi;
        logic signed [ACC_WMAX:0] lo;
        logic        [ACC_WMAX:0] res;
        sum = $signed({a[ACC_WMAX-1], a}) + $signed({b[ACC_WMAX-1], b});
        hi  = $signed({1'b0, ACC_MAX}) >>> (ACC_WMAX - width);
        lo  = $signed({1'b1, ACC_MIN}) >>> (ACC_WMAX - width);
        res = sum;
        if (saturate && (sum > hi)) begin
            res = hi;
        end else if (saturate && (sum < lo)) begin
            res = lo;
        end
        return res[ACC_WMAX-1:0];
    endfunction

endpackage

// File: rtl/acc_accumulate_ctrl_if.sv
// Partial-sum stream, readout request and accumulator-memory port bundle.
interface acc_accumulate_ctrl_if #(
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [PSUM_WIDTH-1:0] in_data;
    logic                  in_first;
    logic                  in_last;
    logic                  ext_rd_req;
    logic [ADDR_WIDTH-1:0] ext_rd_addr;
    logic                  mem_read_req;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [ACC_WIDTH-1:0]  mem_read_data;
    logic                  mem_write_req;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [ACC_WIDTH-1:0]  mem_write_data;

    modport slave (
        input  in_valid, in_addr, in_data, in_first, in_last,
        input  ext_rd_req, ext_rd_addr, mem_read_data,
        output in_ready, mem_read_req, mem_read_addr,
        output mem_write_req, mem_write_addr, mem_write_data
    );

    modport master (
        output in_valid, in_addr, in_data, in_first, in_last,
        output ext_rd_req, ext_rd_addr, mem_read_data,
        input  in_ready, mem_read_req, mem_read_addr,
        input  mem_write_req, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/acc_add_sat.sv
// Sign-extends a partial sum to accumulator width and adds it to an accumulator word (wrap or clamp).
module acc_add_sat
    import acc_pkg::*;
#(
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int SATURATE   = 0
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    input  logic [PSUM_WIDTH-1:0] psum_i,
    output logic [ACC_WIDTH-1:0]  psum_sx_o,
    output logic [ACC_WIDTH-1:0]  sum_o
);
    logic [ACC_WMAX-1:0] acc_wide;
    logic [ACC_WMAX-1:0] psum_wide;

    assign psum_sx_o = ACC_WIDTH'($signed(psum_i));
    assign acc_wide  = ACC_WMAX'($signed(acc_i));
    assign psum_wide = ACC_WMAX'($signed(psum_sx_o));
    assign sum_o     = ACC_WIDTH'(sat_add(acc_wide, psum_wide, ACC_WIDTH, SATURATE != 0));
endmodule

// File: rtl/acc_accumulate_ctrl.sv
// Read-modify-write front end: adds or overwrites streamed partial sums into the accumulator memory,
// with a one-deep write stage forwarded to the next beat because the memory only writes on negedge.
module acc_accumulate_ctrl
    import acc_pkg::*;
#(
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int SATURATE   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    acc_accumulate_ctrl_if.slave bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] beat_count_o
);
    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  s1_valid_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [ACC_WIDTH-1:0]  s1_data_q;
    logic [ACC_WIDTH-1:0]  s1_data_d;

    logic                  in_ready;
    logic                  accept;
    logic                  fwd;
    logic [ACC_WIDTH-1:0]  operand;
    logic [ACC_WIDTH-1:0]  psum_sx;
    logic [ACC_WIDTH-1:0]  sum;

    // The readout engine always owns the read port when it asks for it.
    assign in_ready = rst_n & ~bus.ext_rd_req & (state_q != DRAIN);
    assign accept   = bus.in_valid & in_ready;

    assign bus.in_ready      = in_ready;
    assign bus.mem_read_req  = rst_n & (bus.ext_rd_req | accept);
    assign bus.mem_read_addr = !rst_n ? '0 : (bus.ext_rd_req ? bus.ext_rd_addr : bus.in_addr);

    // The word in S1 has not reached memory yet, so a same-address beat must take it from here.
    assign fwd     = s1_valid_q & (s1_addr_q == bus.in_addr);
    assign operand = fwd ? s1_data_q : bus.mem_read_data;

    acc_add_sat #(
        .PSUM_WIDTH (PSUM_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SATURATE   (SATURATE)
    ) u_add (
        .acc_i     (operand),
        .psum_i    (bus.in_data),
        .psum_sx_o (psum_sx),
        .sum_o     (sum)
    );

    assign s1_data_d = bus.in_first ? psum_sx : sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_addr_q <= bus.in_addr;
                s1_data_q <= s1_data_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_WIDTH'(1);
                    state_d = bus.in_last ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (bus.in_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_write_req  = s1_valid_q;
    assign bus.mem_write_addr = s1_addr_q;
    assign bus.mem_write_data = s1_data_q;

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DRAIN);
    assign beat_count_o = cnt_q;
endmodule

// File: tb/tb_acc_accumulate_ctrl.sv
// Bench: a wrapping and a saturating instance share one stimulus stream; each has its own memory and reference model.
module tb_acc_accumulate_ctrl;
    localparam int PW    = 16;
    localparam int AW    = 32;
    localparam int ADDRW = 4;
    localparam int CW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid, in_first, in_last, ext_rd_req;
    logic [ADDRW-1:0] in_addr, ext_rd_addr;
    logic [PW-1:0]    in_data;

    int n_vec = 0;
    int n_err = 0;

    acc_accumulate_ctrl_if #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADDRW)) if0 ();
    acc_accumulate_ctrl_if #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADDRW)) if1 ();

    logic [AW-1:0]    mem [2][16];
    logic             rdy_s [2], rrq_s [2], wrq_s [2], busy_s [2], done_s [2];
    logic [ADDRW-1:0] rad_s [2], wad_s [2];
    logic [AW-1:0]    wd_s  [2];
    logic [CW-1:0]    cnt_s [2];

    acc_accumulate_ctrl #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADDRW), .SATURATE(0), .CNT_WIDTH(CW)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(if0), .busy_o(busy_s[0]), .done_o(done_s[0]), .beat_count_o(cnt_s[0]));
    acc_accumulate_ctrl #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADDRW), .SATURATE(1), .CNT_WIDTH(CW)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(if1), .busy_o(busy_s[1]), .done_o(done_s[1]), .beat_count_o(cnt_s[1]));

    assign if0.in_valid = in_valid;      assign if1.in_valid = in_valid;
    assign if0.in_addr = in_addr;        assign if1.in_addr = in_addr;
    assign if0.in_data = in_data;        assign if1.in_data = in_data;
    assign if0.in_first = in_first;      assign if1.in_first = in_first;
    assign if0.in_last = in_last;        assign if1.in_last = in_last;
    assign if0.ext_rd_req = ext_rd_req;  assign if1.ext_rd_req = ext_rd_req;
    assign if0.ext_rd_addr = ext_rd_addr; assign if1.ext_rd_addr = ext_rd_addr;
    assign if0.mem_read_data = mem[0][if0.mem_read_addr];
    assign if1.mem_read_data = mem[1][if1.mem_read_addr];
    assign rdy_s[0] = if0.in_ready;      assign rdy_s[1] = if1.in_ready;
    assign rrq_s[0] = if0.mem_read_req;  assign rrq_s[1] = if1.mem_read_req;
    assign rad_s[0] = if0.mem_read_addr; assign rad_s[1] = if1.mem_read_addr;
    assign wrq_s[0] = if0.mem_write_req; assign wrq_s[1] = if1.mem_write_req;
    assign wad_s[0] = if0.mem_write_addr; assign wad_s[1] = if1.mem_write_addr;
    assign wd_s[0] = if0.mem_write_data; assign wd_s[1] = if1.mem_write_data;

    // Accumulator memory: combinational read, write on the falling edge.
    always @(negedge clk) begin
        if (wrq_s[0] === 1'b1) mem[0][wad_s[0]] = wd_s[0];
        if (wrq_s[1] === 1'b1) mem[1][wad_s[1]] = wd_s[1];
    end

    // Reference model state: memory image as it will be once pending writes land.
    logic [AW-1:0]    ref_mem [2][16];
    bit               pend_v  [2];
    logic [ADDRW-1:0] pend_a  [2];
    logic [AW-1:0]    pend_d  [2];
    logic [AW-1:0]    pend_old [2];
    bit               busy_m  [2];
    bit               drain_m [2];
    int               cnt_m   [2];
    logic [35:0]      wlog0 [$];
    logic [35:0]      wlog1 [$];
    int               nrdy_low = 0;

    function automatic logic [AW-1:0] ref_add(input logic [AW-1:0] acc, input logic [PW-1:0] d, input bit sat);
        longint s;
        s = longint'($signed(acc)) + longint'($signed(d));
        if (sat && s > 64'sd2147483647)  s = 64'sd2147483647;
        if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
        return s[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_log(input string nm, input int k, input int idx, input logic [31:0] exp);
        int sz;
        logic [35:0] e;
        sz = (k == 0) ? wlog0.size() : wlog1.size();
        if (idx >= sz) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: write #%0d missing (got %0d writes) expected %h", nm, idx, sz, exp);
        end else begin
            e = (k == 0) ? wlog0[idx] : wlog1[idx];
            chk(nm, e[31:0], exp);
        end
    endtask

    // Per-cycle compare against the model, then advance the model by one clock.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit               er, rq, acc;
            logic [ADDRW-1:0] ra;
            logic [AW-1:0]    nv;
            er = rst_n && !ext_rd_req && !drain_m[k];
            rq = rst_n && (ext_rd_req || (in_valid && er));
            ra = !rst_n ? '0 : (ext_rd_req ? ext_rd_addr : in_addr);
            chk($sformatf("in_ready[%0d]", k), 32'(rdy_s[k]), 32'(er));
            chk($sformatf("mem_read_req[%0d]", k), 32'(rrq_s[k]), 32'(rq));
            chk($sformatf("mem_read_addr[%0d]", k), 32'(rad_s[k]), 32'(ra));
            chk($sformatf("mem_write_req[%0d]", k), 32'(wrq_s[k]), 32'(rst_n && pend_v[k]));
            if (rst_n && pend_v[k]) begin
                chk($sformatf("mem_write_addr[%0d]", k), 32'(wad_s[k]), 32'(pend_a[k]));
                chk($sformatf("mem_write_data[%0d]", k), wd_s[k], pend_d[k]);
            end
            chk($sformatf("busy[%0d]", k), 32'(busy_s[k]), 32'(rst_n && busy_m[k]));
            chk($sformatf("done[%0d]", k), 32'(done_s[k]), 32'(rst_n && drain_m[k]));
            chk($sformatf("beat_count[%0d]", k), 32'(cnt_s[k]), rst_n ? 32'(cnt_m[k]) : 32'd0);
            if (wrq_s[k] === 1'b1) begin
                if (k == 0) wlog0.push_back({wad_s[0], wd_s[0]});
                else        wlog1.push_back({wad_s[1], wd_s[1]});
            end
            if (k == 0 && rst_n && rdy_s[0] !== 1'b1) nrdy_low++;

            if (!rst_n) begin
                if (pend_v[k]) ref_mem[k][pend_a[k]] = pend_old[k];
                pend_v[k]  = 0;
                busy_m[k]  = 0;
                drain_m[k] = 0;
                cnt_m[k]   = 0;
            end else begin
                acc       = in_valid && er;
                pend_v[k] = 0;
                if (drain_m[k]) begin
                    drain_m[k] = 0;
                    busy_m[k]  = 0;
                end
                if (acc) begin
                    nv = in_first ? AW'($signed(in_data)) : ref_add(ref_mem[k][in_addr], in_data, k == 1);
                    pend_old[k] = ref_mem[k][in_addr];
                    ref_mem[k][in_addr] = nv;
                    pend_v[k] = 1;
                    pend_a[k] = in_addr;
                    pend_d[k] = nv;
                    cnt_m[k]  = busy_m[k] ? ((cnt_m[k] < 15) ? cnt_m[k] + 1 : 15) : 1;
                    busy_m[k] = 1;
                    drain_m[k] = in_last;
                end
            end
        end
    end

    task automatic preload(input int a, input logic [AW-1:0] v);
        for (int k = 0; k < 2; k++) begin
            mem[k][a]     = v;
            ref_mem[k][a] = v;
        end
    endtask

    task automatic clear_logs();
        wlog0.delete();
        wlog1.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a beat and returns one step after the edge that accepted it; in_valid is left high.
    task automatic send_beat(input logic [ADDRW-1:0] a, input logic [PW-1:0] d, input bit f, input bit l);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_first = f;
        in_last  = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (rdy_s[0] === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_beat: addr %0d not accepted within 50 cycles", a);
        end
    endtask

    initial begin
        bit will_acc;
        int rst_hold;
        rst_n = 1'b0; in_valid = 0; in_first = 0; in_last = 0; ext_rd_req = 0;
        in_addr = '0; ext_rd_addr = '0; in_data = '0;
        for (int a = 0; a < 16; a++) preload(a, $urandom);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // T1: 10 + 3 at address 5
        preload(5, 32'd10);
        clear_logs();
        send_beat(4'd5, 16'd3, 0, 1);
        idle(4);
        chk("T1 nwrites", 32'(wlog0.size()), 32'd1);
        chk_log("T1 wrap", 0, 0, 32'd13);
        chk_log("T1 sat", 1, 0, 32'd13);

        // T2: back-to-back same address
        clear_logs();
        send_beat(4'd7, 16'd1, 1, 0);
        send_beat(4'd7, 16'd2, 0, 0);
        send_beat(4'd7, 16'd3, 0, 0);
        send_beat(4'd7, 16'd4, 0, 1);
        idle(4);
        chk_log("T2 w0", 0, 0, 32'd1);
        chk_log("T2 w1", 0, 1, 32'd3);
        chk_log("T2 w2", 0, 2, 32'd6);
        chk_log("T2 w3", 0, 3, 32'd10);
        chk("T2 beat_count", 32'(cnt_s[0]), 32'd4);

        // T3: readout steals the read port for three cycles mid-stream
        clear_logs();
        nrdy_low = 0;
        fork
            begin
                for (int j = 0; j < 6; j++) send_beat(4'(j + 8), 16'(j + 1), 1, 0);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                ext_rd_req = 1'b1;
                ext_rd_addr = 4'd9;
                repeat (3) @(posedge clk);
                #1;
                ext_rd_req = 1'b0;
            end
        join
        idle(3);
        chk("T3 ready-low cycles", 32'(nrdy_low), 32'd3);
        chk("T3 nwrites", 32'(wlog0.size()), 32'd6);
        for (int j = 0; j < 6; j++) chk_log($sformatf("T3 w%0d", j), 0, j, 32'(j + 1));

        // T4: overflow, wrap vs clamp
        preload(0, 32'h7FFF_FFF0);
        clear_logs();
        send_beat(4'd0, 16'h0020, 0, 1);
        idle(4);
        chk_log("T4 wrap", 0, 0, 32'h8000_0010);
        chk_log("T4 sat", 1, 0, 32'h7FFF_FFFF);

        // T5: negative partial sum sign-extension
        preload(3, 32'd5);
        clear_logs();
        send_beat(4'd3, 16'hFFFF, 0, 1);
        idle(4);
        chk_log("T5 wrap", 0, 0, 32'd4);
        chk_log("T5 sat", 1, 0, 32'd4);

        // T6: reset while a write is in flight
        preload(2, 32'd100);
        send_beat(4'd2, 16'd5, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("T6 write_req", 32'(wrq_s[0]), 32'd0);
        chk("T6 busy", 32'(busy_s[0]), 32'd0);
        chk("T6 done", 32'(done_s[0]), 32'd0);
        chk("T6 beat_count", 32'(cnt_s[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        send_beat(4'd2, 16'd7, 0, 1);
        idle(4);
        chk_log("T6 after reset", 0, 0, 32'd107);
        chk("T6 beat_count after", 32'(cnt_s[0]), 32'd1);

        // Random traffic over a memory seeded near the signed limits
        for (int a = 0; a < 16; a++) begin
            case ($urandom_range(0, 2))
                0:       preload(a, 32'h7FFF_0000 + 32'($urandom_range(0, 65535)));
                1:       preload(a, 32'h8000_FFFF - 32'($urandom_range(0, 65535)));
                default: preload(a, $urandom);
            endcase
        end
        rst_hold = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            will_acc = in_valid && (rdy_s[0] === 1'b1);
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rst_hold--;
                if (rst_hold <= 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                rst_hold = 2;
            end
            if (!in_valid || will_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_addr  = 4'($urandom_range(0, 15));
                in_data  = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 40) - 20);
                in_first = ($urandom_range(0, 3) == 0);
                in_last  = ($urandom_range(0, 9) == 0);
            end
            ext_rd_req  = ($urandom_range(0, 5) == 0);
            ext_rd_addr = 4'($urandom_range(0, 15));
        end
        in_valid = 1'b0;
        ext_rd_req = 1'b0;
        rst_n = 1'b1;
        idle(6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
